ntt_stage_sched: RTL
====================

NTT_STAGE_SCHED -- requirements
Module: ntt_stage_sched

Interface
- REQ-001: Parameter LOGN, default 8; log2 of transform size N; legal range 2..15.
- REQ-002: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-003: reset  input  1  asynchronous, active-low reset.
- REQ-004: start  input  1  single-cycle request to run one full transform.
- REQ-005: cfg_lat  input  3  butterfly-path delay select for the run; values above 5 are clamped to 5.
- REQ-006: sel  output  3  delay select driven to the butterfly delay line; latency L = 7 + sel cycles.
- REQ-007: rd_en  output  1  butterfly read strobe.
- REQ-008: rd_addr  output  LOGN-1  butterfly read index.
- REQ-009: wr_en  output  1  writeback strobe, aligned to delay-line output.
- REQ-010: wr_addr  output  LOGN-1  writeback index.
- REQ-011: stage  output  4  current stage index, 0..LOGN-1.
- REQ-012: busy  output  1  a run is in progress.
- REQ-013: done  output  1  one-cycle run-complete pulse.

Function
- REQ-014: The block SHALL implement a state machine with states IDLE, RUN, DRAIN and DONE.
- REQ-015: In IDLE, start=1 SHALL latch clamp(cfg_lat) into sel, clear stage and the read counter, and move to RUN.
- REQ-016: sel SHALL hold constant from the latch cycle until the next accepted start; a cfg_lat change mid-run SHALL have no effect.
- REQ-017: In RUN, rd_en SHALL be 1 every cycle, with rd_addr stepping 0, 1, ..., N/2-1 (one index per cycle); after index N/2-1 the state SHALL move to DRAIN.
- REQ-018: For every read issued in cycle t, the block SHALL assert wr_en in cycle t+L with wr_addr equal to that read's rd_addr, using an internal 12-deep valid/address pipeline tapped by sel.
- REQ-019: DRAIN SHALL last until the cycle in which wr_en=1 with wr_addr=N/2-1.
- REQ-020: Leaving DRAIN: if stage < LOGN-1, the next cycle SHALL be RUN with stage+1 and rd_addr=0; otherwise the next cycle SHALL be DONE.
- REQ-021: Read and write SHALL never overlap within a run: no rd_en while a previous stage's writes are still pending.
- REQ-022: DONE SHALL last exactly one cycle with done=1, then return to IDLE.
- REQ-023: busy SHALL be 1 in RUN, DRAIN and DONE, and 0 in IDLE.
- REQ-024: start while busy=1 SHALL be ignored, with no restart and no counter change.
- REQ-025: rd_addr and wr_addr SHALL wrap naturally at N/2; no other index values SHALL be produced.
- REQ-026: rd_addr and wr_addr SHALL hold their last value when the corresponding strobe is 0.

Reset
- REQ-027: reset=0 SHALL force, asynchronously: state IDLE, sel=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, stage=0, busy=0, done=0, and all internal pipeline valid bits cleared.
- REQ-028: reset asserted mid-run SHALL abort the run; no wr_en or done SHALL follow reset release until a new start.
- REQ-029: The first start SHALL be accepted in the first clock edge after reset deasserts.

Verification
- REQ-030: LOGN=3, cfg_lat=0, start in cycle 0 -> rd_en cycles 1-4 (addr 0-3), wr_en cycles 8-11; stage 1 rd 12-15, wr 19-22; stage 2 rd 23-26, wr 30-33; done in cycle 34; busy in cycles 1-34.
- REQ-031: LOGN=3, cfg_lat=7 -> sel=5, L=12; first wr_en in cycle 13, done in cycle 49.
- REQ-032: start repeated in cycles 5 and 20 of the run in REQ-030 -> identical waveform; done only in cycle 34.
- REQ-033: cfg_lat changed from 0 to 4 in cycle 3 of the run in REQ-030 -> sel stays 0; timing unchanged.
- REQ-034: reset=0 in cycle 10 of the run in REQ-030 -> all outputs 0 immediately; no wr_en or done afterward; a new start in cycle 15 reproduces REQ-030 shifted by 15 cycles.
- REQ-035: LOGN=2, cfg_lat=3, back-to-back starts (second start in the cycle after done) -> each run gives 2 stages of 2 reads, with writes 10 cycles after each read, and exactly one done per run.

Source files
------------

// File: rtl/ntt_stage_sched.sv
// Stage scheduler for an in-place NTT: issues N/2 butterfly reads per stage and
// replays each read as a writeback after the selected delay-line latency.
module ntt_stage_sched #(
  parameter int LOGN = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      cfg_lat,
  output logic [2:0]      sel,
  output logic            rd_en,
  output logic [LOGN-2:0] rd_addr,
  output logic            wr_en,
  output logic [LOGN-2:0] wr_addr,
  output logic [3:0]      stage,
  output logic            busy,
  output logic            done,
  output logic [1:0]      dbg_state
);

  // Handshake: none. start is a one-cycle request honoured only while busy=0;
  // rd_en/wr_en are qualifying strobes with no back-pressure.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int             AW         = LOGN - 1;
  localparam int             DEPTH      = 12;
  localparam logic [AW-1:0]  LAST_IDX   = '1;
  localparam logic [3:0]     LAST_STAGE = 4'(LOGN - 1);
  localparam logic [2:0]     SEL_MAX    = 3'd5;
  localparam logic [3:0]     TAP_BASE   = 4'd6;

  logic [1:0]                 state_q, state_d;
  logic [2:0]                 sel_q, sel_d;
  logic [AW-1:0]              rd_addr_q, rd_addr_d;
  logic [3:0]                 stage_q, stage_d;
  logic [DEPTH-1:0]           pipe_vld_q, pipe_vld_d;
  logic [DEPTH-1:0][AW-1:0]   pipe_addr_q, pipe_addr_d;
  logic [AW-1:0]              wr_hold_q, wr_hold_d;

  logic [3:0]                 tap_idx;
  logic                       tap_vld;
  logic [AW-1:0]              tap_addr;

  // Pipe entry k holds the read issued k+1 cycles ago, so entry 6+sel lines up
  // with cycle t + 7 + sel.
  always_comb begin
    tap_idx  = TAP_BASE + {1'b0, sel_q};
    tap_vld  = pipe_vld_q[tap_idx];
    tap_addr = pipe_addr_q[tap_idx];
  end

  always_comb begin
    rd_en     = (state_q == S_RUN);
    rd_addr   = rd_addr_q;
    wr_en     = tap_vld;
    wr_addr   = tap_vld ? tap_addr : wr_hold_q;
    sel       = sel_q;
    stage     = stage_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    dbg_state = state_q;
  end

  always_comb begin
    pipe_vld_d  = {pipe_vld_q[DEPTH-2:0], rd_en};
    pipe_addr_d = {pipe_addr_q[DEPTH-2:0], rd_addr_q};
    wr_hold_d   = wr_addr;
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rd_addr_d = rd_addr_q;
    stage_d   = stage_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d     = (cfg_lat > SEL_MAX) ? SEL_MAX : cfg_lat;
          rd_addr_d = '0;
          stage_d   = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (rd_addr_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // The stage's last writeback retires this cycle; only then may the next stage read.
        if (tap_vld && (tap_addr == LAST_IDX)) begin
          if (stage_q == LAST_STAGE) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_RUN;
            stage_d   = stage_q + 4'd1;
            rd_addr_d = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      rd_addr_q   <= '0;
      stage_q     <= '0;
      pipe_vld_q  <= '0;
      pipe_addr_q <= '0;
      wr_hold_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rd_addr_q   <= rd_addr_d;
      stage_q     <= stage_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
      wr_hold_q   <= wr_hold_d;
    end
  end

endmodule
